packet_rr_scheduler: RTL

- Per-output-port scheduler for the simple_mesh_xy switch. Shares one output port between PORT_N input buffers.
- Replaces fixed-priority selection with round-robin arbitration plus a wormhole lock.
- Once an input wins, the output mux stays on that input until its tail flit transfers. The lock is then released and priority rotates.
- Drives the output mux select, the output valid, and the per-input pop grants.

---
 rtl/packet_rr_scheduler_pkg.sv | 9 +
 rtl/packet_rr_scheduler_rr_pick.sv | 22 ++
 rtl/packet_rr_scheduler.sv | 87 ++++++++
 3 files changed

// File: rtl/packet_rr_scheduler_pkg.sv
// packet_rr_scheduler_pkg: shared scheduler state encoding, flit last-bit position and watchdog default.
package packet_rr_scheduler_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;
  localparam int FLIT_LAST_POS = 33;
  localparam int WATCHDOG_CYC_DEF = 64;
endpackage

// File: rtl/packet_rr_scheduler_rr_pick.sv
// packet_rr_scheduler_rr_pick: combinational round-robin picker, first request after ptr with modulo-PORT_N wrap.
module packet_rr_scheduler_rr_pick #(
  parameter int PORT_N = 5,
  localparam int SEL_W = $clog2(PORT_N)
) (
  input  logic [PORT_N-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              any_o,
  output logic [SEL_W-1:0]  idx_o
);
  logic [SEL_W-1:0] c;
  assign any_o = |req_i;
  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    c = '0;
    idx_o = '0;
    for (int k = PORT_N; k >= 1; k--) begin
      c = SEL_W'((int'(ptr_i) + k) % PORT_N);
      if (req_i[c]) idx_o = c;
    end
  end
endmodule

// File: rtl/packet_rr_scheduler.sv
// packet_rr_scheduler: round-robin output scheduler with wormhole lock held until the owner's tail transfers.
// Define ARB_WATCHDOG_EN to add a stall watchdog that force-releases a lock after WATCHDOG_CYC idle cycles.
module packet_rr_scheduler
  import packet_rr_scheduler_pkg::*;
#(
  parameter int PORT_N = 5,
  parameter int WATCHDOG_CYC = WATCHDOG_CYC_DEF,
  localparam int SEL_W = $clog2(PORT_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PORT_N-1:0] req_vld_i,
  input  logic [PORT_N-1:0] req_last_i,
  input  logic              out_rdy_i,
  output logic              out_vld_o,
  output logic [PORT_N-1:0] gnt_o,
  output logic [SEL_W-1:0]  mux_in_sel_o,
  output logic              lock_o,
  output logic              wd_fire_o
);
  if (PORT_N < 2 || PORT_N > 8 || WATCHDOG_CYC < 1) begin : g_bad_cfg
    $error("packet_rr_scheduler: PORT_N must be 2..8 and WATCHDOG_CYC >= 1");
  end
  sched_state_e state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d, ptr_q, ptr_d, pick;
  logic any_req, locked, xfer, wd_trip;
  packet_rr_scheduler_rr_pick #(.PORT_N(PORT_N)) u_pick (
    .req_i(req_vld_i),
    .ptr_i(ptr_q),
    .any_o(any_req),
    .idx_o(pick)
  );
  assign locked = state_q == LOCKED;
  assign out_vld_o = locked & req_vld_i[owner_q];
  assign xfer = out_vld_o & out_rdy_i;
  assign gnt_o = xfer ? (PORT_N'(1) << owner_q) : '0;
  assign mux_in_sel_o = owner_q;
  assign lock_o = locked;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    if (!locked && any_req) begin
      owner_d = pick;
      state_d = LOCKED;
    end
    if ((xfer && req_last_i[owner_q]) || wd_trip) begin
      state_d = IDLE;
      ptr_d = owner_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= SEL_W'(PORT_N - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic wd_fire_q, wd_fire_d;
  // Trip on the stall cycle that would bring the count to WATCHDOG_CYC.
  assign wd_trip = locked & ~xfer & (wd_cnt_q == WD_W'(WATCHDOG_CYC - 1));
  always_comb begin
    wd_cnt_d = (locked && !xfer && !wd_trip) ? wd_cnt_q + 1'b1 : '0;
    wd_fire_d = wd_trip;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      wd_fire_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_fire_q <= wd_fire_d;
    end
  end
  assign wd_fire_o = wd_fire_q;
`else
  assign wd_trip = 1'b0;
  assign wd_fire_o = 1'b0;
`endif
endmodule
